// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_minuend;
  logic [WIDTH-1:0] i_subtrahend;
  logic             i_borrow_in;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_diff;
  logic             o_borrow;

  // Requester side: drives operands, observes status and result.
  modport master (
    output i_start, i_minuend, i_subtrahend, i_borrow_in,
    input  o_busy, o_done, o_diff, o_borrow
  );

  // Subtractor side.
  modport slave (
    input  i_start, i_minuend, i_subtrahend, i_borrow_in,
    output o_busy, o_done, o_diff, o_borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: diff = A - B - borrow_in.
// One bit per clock through a registered borrow; result lands on DONE.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;
  logic             w_accept;

  // Full-subtractor step on the current LSBs and the running borrow.
  assign w_a        = r_a[0];
  assign w_b        = r_b[0];
  assign w_d        = w_a ^ w_b ^ r_br;
  assign w_br_next  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  assign w_accept   = bus.i_start && (r_state != S_RUN);

  // Control FSM plus serial datapath; status and result are registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_a     <= bus.i_minuend;
            r_b     <= bus.i_subtrahend;
            r_br    <= bus.i_borrow_in;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_res <= w_res_next;
          r_br  <= w_br_next;
          if (r_cnt == LAST_BIT) begin
            r_diff   <= w_res_next;
            r_borrow <= w_br_next;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;
  assign bus.o_diff   = r_diff;
  assign bus.o_borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH 8, 2 and 32.
module tb_serial_subtractor;

  logic clk;
  logic rst;

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(2))  bus2 ();
  serial_subtractor_if #(.WIDTH(32)) bus32 ();

  serial_subtractor #(.WIDTH(8))  dut8  (.i_clk(clk), .i_rst(rst), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(2))  dut2  (.i_clk(clk), .i_rst(rst), .bus(bus2.slave));
  serial_subtractor #(.WIDTH(32)) dut32 (.i_clk(clk), .i_rst(rst), .bus(bus32.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       borrow;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Present a request to the 8-bit DUT for exactly one sampling edge.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    bus8.i_minuend    = a;
    bus8.i_subtrahend = b;
    bus8.i_borrow_in  = bin;
    bus8.i_start      = 1'b1;
    @(posedge clk); #1;
    bus8.i_start      = 1'b0;
  endtask

  // Count edges after the accept edge until o_done; also count busy cycles.
  task automatic wait_done8(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = bus8.o_busy ? 1 : 0;
    while (edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (bus8.o_done) break;
      if (bus8.o_busy) busy_cnt++;
    end
    if (!bus8.o_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done8_timeout: got no o_done expected o_done within 40 edges");
    end
  endtask

  int edges;
  int busy_cnt;
  int done_seen;
  logic [31:0] ra, rb;
  logic        rbin;
  logic [32:0] full;
  logic [2:0]  full2;

  initial begin
    rst = 1'b1;
    bus8.i_start = 1'b0;  bus8.i_minuend = '0;  bus8.i_subtrahend = '0;  bus8.i_borrow_in = 1'b0;
    bus2.i_start = 1'b0;  bus2.i_minuend = '0;  bus2.i_subtrahend = '0;  bus2.i_borrow_in = 1'b0;
    bus32.i_start = 1'b0; bus32.i_minuend = '0; bus32.i_subtrahend = '0; bus32.i_borrow_in = 1'b0;

    vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h09, 8'h04, 1'b0, 8'h05, 1'b0};
    vecs[5] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[6] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};

    // Reset at time 0, before any clock edge.
    #1;
    chk("rst0_busy",   32'(bus8.o_busy),   32'h0);
    chk("rst0_done",   32'(bus8.o_done),   32'h0);
    chk("rst0_diff",   32'(bus8.o_diff),   32'h0);
    chk("rst0_borrow", 32'(bus8.o_borrow), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven operations with latency, busy length and single-pulse checks.
    for (int i = 0; i < 8; i++) begin
      start8(vecs[i].a, vecs[i].b, vecs[i].bin);
      wait_done8(edges, busy_cnt);
      chk($sformatf("v%0d_latency", i), 32'(edges), 32'd8);
      chk($sformatf("v%0d_busy", i),    32'(busy_cnt), 32'd8);
      chk($sformatf("v%0d_diff", i),    32'(bus8.o_diff), 32'(vecs[i].diff));
      chk($sformatf("v%0d_borrow", i),  32'(bus8.o_borrow), 32'(vecs[i].borrow));
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(bus8.o_done), 32'h0);
      chk($sformatf("v%0d_diff_hold", i),  32'(bus8.o_diff), 32'(vecs[i].diff));
    end

    // Asynchronous reset while idle with a nonzero held result (0xFE).
    rst = 1'b1;
    #1;
    chk("rst_idle_diff",   32'(bus8.o_diff),   32'h0);
    chk("rst_idle_borrow", 32'(bus8.o_borrow), 32'h0);
    chk("rst_idle_busy",   32'(bus8.o_busy),   32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // i_start during RUN must be ignored.
    start8(8'h80, 8'h01, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus8.i_minuend = 8'h11; bus8.i_subtrahend = 8'h11; bus8.i_start = 1'b1;
    @(posedge clk); #1;
    bus8.i_start = 1'b0;
    edges = 3; done_seen = 0;
    while (edges < 40 && !bus8.o_done) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("ign_latency", 32'(edges), 32'd8);
    chk("ign_diff",    32'(bus8.o_diff), 32'h7F);
    chk("ign_borrow",  32'(bus8.o_borrow), 32'h0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus8.o_done) done_seen++;
    end
    chk("ign_single_done", 32'(done_seen), 32'd0);

    // Back-to-back: new request accepted in the DONE cycle.
    start8(8'h5A, 8'h23, 1'b0);
    wait_done8(edges, busy_cnt);
    chk("b2b_first_diff", 32'(bus8.o_diff), 32'h37);
    start8(8'h03, 8'h05, 1'b0);
    chk("b2b_accepted_busy", 32'(bus8.o_busy), 32'h1);
    done_seen = 0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      if (bus8.o_done) done_seen++;
      if (bus8.o_diff !== 8'h37) chk("b2b_hold_diff", 32'(bus8.o_diff), 32'h37);
    end
    chk("b2b_no_early_done", 32'(done_seen), 32'd0);
    chk("b2b_hold_diff_end", 32'(bus8.o_diff), 32'h37);
    @(posedge clk); #1;
    chk("b2b_done",   32'(bus8.o_done),   32'h1);
    chk("b2b_diff",   32'(bus8.o_diff),   32'hFE);
    chk("b2b_borrow", 32'(bus8.o_borrow), 32'h1);
    @(posedge clk); #1;

    // Reset after 4 RUN edges abandons the operation.
    start8(8'hFF, 8'h01, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("rst_run_busy",   32'(bus8.o_busy),   32'h0);
    chk("rst_run_diff",   32'(bus8.o_diff),   32'h0);
    chk("rst_run_borrow", 32'(bus8.o_borrow), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus8.o_done) done_seen++;
    end
    chk("rst_run_no_done", 32'(done_seen), 32'd0);
    start8(8'h09, 8'h04, 1'b0);
    wait_done8(edges, busy_cnt);
    chk("post_rst_latency", 32'(edges), 32'd8);
    chk("post_rst_diff",    32'(bus8.o_diff), 32'h05);
    chk("post_rst_borrow",  32'(bus8.o_borrow), 32'h0);
    @(posedge clk); #1;

    // Random compare, WIDTH=2.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(1, 0));
      full2 = {1'b0, ra[1:0]} - {1'b0, rb[1:0]} - 3'(rbin);
      bus2.i_minuend = ra[1:0]; bus2.i_subtrahend = rb[1:0]; bus2.i_borrow_in = rbin;
      bus2.i_start = 1'b1;
      @(posedge clk); #1;
      bus2.i_start = 1'b0;
      edges = 0;
      while (edges < 10 && !bus2.o_done) begin
        @(posedge clk); #1;
        edges++;
      end
      chk($sformatf("w2_%0d_latency", i), 32'(edges), 32'd2);
      chk($sformatf("w2_%0d_diff", i),    32'(bus2.o_diff), 32'(full2[1:0]));
      chk($sformatf("w2_%0d_borrow", i),  32'(bus2.o_borrow), 32'(full2[2]));
    end

    // Random compare, WIDTH=32.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(1, 0));
      if (i == 0) begin ra = 32'h0; rb = 32'h0; rbin = 1'b1; end
      if (i == 1) begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; rbin = 1'b0; end
      full = {1'b0, ra} - {1'b0, rb} - 33'(rbin);
      bus32.i_minuend = ra; bus32.i_subtrahend = rb; bus32.i_borrow_in = rbin;
      bus32.i_start = 1'b1;
      @(posedge clk); #1;
      bus32.i_start = 1'b0;
      edges = 0;
      while (edges < 60 && !bus32.o_done) begin
        @(posedge clk); #1;
        edges++;
      end
      chk($sformatf("w32_%0d_latency", i), 32'(edges), 32'd32);
      chk($sformatf("w32_%0d_diff", i),    bus32.o_diff, full[31:0]);
      chk($sformatf("w32_%0d_borrow", i),  32'(bus32.o_borrow), 32'(full[32]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
